// File: rtl/inc8_sched.sv
// inc8_sched: two-requester scheduler for a shared 4-bit add-with-carry datapath.
// Each granted operation adds a 1-bit carry-in to an 8-bit operand in two nibble passes.
module inc8_sched #(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic       cin0,
    input  logic       cin1,
    output logic [3:0] add_a,
    output logic       add_cin,
    input  logic [4:0] add_ac,
    output logic [1:0] gnt,
    output logic       busy,
    output logic       done,
    output logic       done_id,
    output logic [7:0] result,
    output logic       cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state;
    logic [3:0] op_hi;
    logic [3:0] res_lo;
    logic       mid_c;
    logic       cur_id;
    logic       last_win;
    logic       win;

    // Tie goes to whoever did not win last; last_win resets to 1 so requester 0 wins first.
    always_comb begin
        win = 1'b0;
        if (req0 && req1) begin
            win = RR_EN ? ~last_win : 1'b0;
        end else if (req1) begin
            win = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_hi    <= 4'h0;
            res_lo   <= 4'h0;
            mid_c    <= 1'b0;
            cur_id   <= 1'b0;
            last_win <= 1'b1;
            add_a    <= 4'h0;
            add_cin  <= 1'b0;
            gnt      <= 2'b00;
            busy     <= 1'b0;
            done     <= 1'b0;
            done_id  <= 1'b0;
            result   <= 8'h00;
            cout     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        state   <= LOW;
                        busy    <= 1'b1;
                        cur_id  <= win;
                        op_hi   <= win ? data1[7:4] : data0[7:4];
                        add_a   <= win ? data1[3:0] : data0[3:0];
                        add_cin <= win ? cin1 : cin0;
                        gnt     <= win ? 2'b10 : 2'b01;
                    end
                end
                LOW: begin
                    state   <= HIGH;
                    gnt     <= 2'b00;
                    res_lo  <= add_ac[3:0];
                    mid_c   <= add_ac[4];
                    add_a   <= op_hi;
                    add_cin <= add_ac[4];
                end
                HIGH: begin
                    state   <= DONE;
                    done    <= 1'b1;
                    done_id <= cur_id;
                    result  <= {add_ac[3:0], res_lo};
                    cout    <= add_ac[4];
                    add_a   <= 4'h0;
                    add_cin <= 1'b0;
                end
                DONE: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    last_win <= cur_id;
                    mid_c    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inc8_sched.sv
// Bench for inc8_sched: vector table, hand-written corner sequences,
// and random traffic against an arithmetic reference model.
module tb_inc8_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] data0 = 8'h00, data1 = 8'h00;
    logic       cin0 = 1'b0, cin1 = 1'b0;

    logic [3:0] a_rr, a_fp;
    logic       ci_rr, ci_fp;
    logic [4:0] ac_rr, ac_fp;
    logic [1:0] gnt_rr, gnt_fp;
    logic       busy_rr, busy_fp, done_rr, done_fp, id_rr, id_fp;
    logic [7:0] res_rr, res_fp;
    logic       cout_rr, cout_fp;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign ac_rr = {1'b0, a_rr} + {4'b0, ci_rr};
    assign ac_fp = {1'b0, a_fp} + {4'b0, ci_fp};

    inc8_sched #(.RR_EN(1'b1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .data0(data0), .data1(data1), .cin0(cin0), .cin1(cin1),
        .add_a(a_rr), .add_cin(ci_rr), .add_ac(ac_rr), .gnt(gnt_rr),
        .busy(busy_rr), .done(done_rr), .done_id(id_rr),
        .result(res_rr), .cout(cout_rr)
    );

    inc8_sched #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .data0(data0), .data1(data1), .cin0(cin0), .cin1(cin1),
        .add_a(a_fp), .add_cin(ci_fp), .add_ac(ac_fp), .gnt(gnt_fp),
        .busy(busy_fp), .done(done_fp), .done_id(id_fp),
        .result(res_fp), .cout(cout_fp)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " gnt"}, 32'(gnt_rr), 32'h0);
        chk({tag, " busy"}, 32'(busy_rr), 32'h0);
        chk({tag, " done"}, 32'(done_rr), 32'h0);
        chk({tag, " add_a"}, 32'(a_rr), 32'h0);
        chk({tag, " add_cin"}, 32'(ci_rr), 32'h0);
    endtask

    task automatic chk_reset(input string tag);
        chk_idle(tag);
        chk({tag, " result"}, 32'(res_rr), 32'h0);
        chk({tag, " cout"}, 32'(cout_rr), 32'h0);
        chk({tag, " done_id"}, 32'(id_rr), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        #1 chk_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       r0, r1;
        logic [7:0] d0, d1;
        logic       c0, c1;
        logic [1:0] e_gnt;
        logic [7:0] e_res;
        logic       e_cout, e_id;
        logic [3:0] e_alo, e_ahi;
        logic       e_clo, e_chi;
    } vec_t;

    // Starts from IDLE at a negedge; request sampled at the next posedge.
    task automatic run_vec(input vec_t v, input int idx);
        string t;
        t = $sformatf("vec%0d", idx);
        req0 = v.r0; req1 = v.r1;
        data0 = v.d0; data1 = v.d1;
        cin0 = v.c0; cin1 = v.c1;
        @(negedge clk);
        chk({t, " low gnt"}, 32'(gnt_rr), 32'(v.e_gnt));
        chk({t, " low busy"}, 32'(busy_rr), 32'h1);
        chk({t, " low add_a"}, 32'(a_rr), 32'(v.e_alo));
        chk({t, " low add_cin"}, 32'(ci_rr), 32'(v.e_clo));
        chk({t, " low done"}, 32'(done_rr), 32'h0);
        req0 = 1'b0; req1 = 1'b0;
        data0 = ~v.d0; data1 = ~v.d1;
        cin0 = ~v.c0; cin1 = ~v.c1;
        @(negedge clk);
        chk({t, " high gnt"}, 32'(gnt_rr), 32'h0);
        chk({t, " high add_a"}, 32'(a_rr), 32'(v.e_ahi));
        chk({t, " high add_cin"}, 32'(ci_rr), 32'(v.e_chi));
        @(negedge clk);
        chk({t, " done"}, 32'(done_rr), 32'h1);
        chk({t, " result"}, 32'(res_rr), 32'(v.e_res));
        chk({t, " cout"}, 32'(cout_rr), 32'(v.e_cout));
        chk({t, " done_id"}, 32'(id_rr), 32'(v.e_id));
        chk({t, " done add_a"}, 32'(a_rr), 32'h0);
        @(negedge clk);
        chk({t, " idle done"}, 32'(done_rr), 32'h0);
        chk({t, " idle busy"}, 32'(busy_rr), 32'h0);
        chk({t, " hold result"}, 32'(res_rr), 32'(v.e_res));
        chk({t, " hold cout"}, 32'(cout_rr), 32'(v.e_cout));
    endtask

    vec_t vt[6];

    // Reference model state for random traffic
    int         m_phase;
    logic       m_last, m_w, m_lc;
    logic [7:0] m_op;
    logic [8:0] m_sum;
    logic [1:0] m_gnt;
    logic       m_busy, m_done, m_id, m_cout, m_ci, m_acin;
    logic [7:0] m_res;
    logic [3:0] m_aa;

    initial begin
        vt[0] = '{1,0, 8'h0F,8'h00, 1,0, 2'b01, 8'h10,0,0, 4'hF,4'h0, 1,1};
        vt[1] = '{0,1, 8'h00,8'hFF, 0,1, 2'b10, 8'h00,1,1, 4'hF,4'hF, 1,1};
        vt[2] = '{1,0, 8'hA5,8'h00, 0,0, 2'b01, 8'hA5,0,0, 4'h5,4'hA, 0,0};
        vt[3] = '{1,1, 8'h11,8'h80, 0,1, 2'b10, 8'h81,0,1, 4'h0,4'h8, 1,0};
        vt[4] = '{1,1, 8'h7F,8'h01, 1,0, 2'b01, 8'h80,0,0, 4'hF,4'h7, 1,1};
        vt[5] = '{0,1, 8'h00,8'h8F, 0,1, 2'b10, 8'h90,0,1, 4'hF,4'h8, 1,1};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_idle("idle10");
        end

        for (int i = 0; i < 6; i++) run_vec(vt[i], i);

        // Abort in HIGH, then a clean operation.
        req0 = 1'b1; data0 = 8'h5C; cin0 = 1'b1;
        @(negedge clk);
        req0 = 1'b0;
        @(negedge clk);
        chk("abort in high", 32'(busy_rr), 32'h1);
        #2 rst_n = 1'b0;
        #1 chk_reset("abort");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort no done", 32'(done_rr), 32'h0);
        end
        run_vec('{1,0, 8'h3F,8'h00, 1,0, 2'b01, 8'h40,0,0, 4'hF,4'h3, 1,1}, 6);

        // Both requests held from reset: RR alternates, fixed priority keeps requester 0.
        begin
            logic [1:0] g_rr[$], g_fp[$];
            int d_cyc[$];
            @(negedge clk);
            rst_n = 1'b0;
            req0 = 1'b1; req1 = 1'b1;
            data0 = 8'h01; data1 = 8'h02; cin0 = 1'b0; cin1 = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            for (int c = 0; c < 40 && d_cyc.size() < 4; c++) begin
                @(negedge clk);
                if (gnt_rr != 2'b00) g_rr.push_back(gnt_rr);
                if (gnt_fp != 2'b00) g_fp.push_back(gnt_fp);
                if (done_rr) d_cyc.push_back(c);
            end
            chk("tie rr count", 32'(g_rr.size()), 32'd4);
            chk("tie fp count", 32'(g_fp.size()), 32'd4);
            chk("tie done count", 32'(d_cyc.size()), 32'd4);
            for (int i = 0; i < g_rr.size() && i < 4; i++)
                chk($sformatf("tie rr gnt%0d", i), 32'(g_rr[i]),
                    (i % 2 == 0) ? 32'h1 : 32'h2);
            for (int i = 0; i < g_fp.size() && i < 4; i++)
                chk($sformatf("tie fp gnt%0d", i), 32'(g_fp[i]), 32'h1);
            for (int i = 1; i < d_cyc.size(); i++)
                chk($sformatf("tie done gap%0d", i), 32'(d_cyc[i] - d_cyc[i-1]), 32'd4);
            req0 = 1'b0; req1 = 1'b0;
        end

        // Random traffic against the reference model.
        @(negedge clk);
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_phase = 0; m_last = 1'b1; m_w = 1'b0; m_op = 8'h00; m_ci = 1'b0;
        m_sum = 9'h0; m_lc = 1'b0;
        m_gnt = 2'b00; m_busy = 1'b0; m_done = 1'b0; m_id = 1'b0;
        m_res = 8'h00; m_cout = 1'b0; m_aa = 4'h0; m_acin = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            chk("rnd gnt", 32'(gnt_rr), 32'(m_gnt));
            chk("rnd busy", 32'(busy_rr), 32'(m_busy));
            chk("rnd done", 32'(done_rr), 32'(m_done));
            chk("rnd add_a", 32'(a_rr), 32'(m_aa));
            chk("rnd add_cin", 32'(ci_rr), 32'(m_acin));
            chk("rnd result", 32'(res_rr), 32'(m_res));
            chk("rnd cout", 32'(cout_rr), 32'(m_cout));
            chk("rnd done_id", 32'(id_rr), 32'(m_id));
            req0 = ($urandom_range(0, 2) == 0);
            req1 = ($urandom_range(0, 2) == 0);
            data0 = 8'($urandom);
            data1 = 8'($urandom);
            cin0 = 1'($urandom);
            cin1 = 1'($urandom);
            m_done = 1'b0;
            if (m_phase == 0) begin
                if (req0 || req1) begin
                    m_w = (req0 && req1) ? !m_last : req1;
                    m_op = m_w ? data1 : data0;
                    m_ci = m_w ? cin1 : cin0;
                    m_sum = 9'(m_op) + 9'(m_ci);
                    m_lc = (int'(m_op[3:0]) + int'(m_ci)) > 15;
                    m_gnt = m_w ? 2'b10 : 2'b01;
                    m_aa = m_op[3:0];
                    m_acin = m_ci;
                    m_busy = 1'b1;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                m_gnt = 2'b00;
                m_aa = m_op[7:4];
                m_acin = m_lc;
                m_phase = 2;
            end else if (m_phase == 2) begin
                m_done = 1'b1;
                m_res = m_sum[7:0];
                m_cout = m_sum[8];
                m_id = m_w;
                m_aa = 4'h0;
                m_acin = 1'b0;
                m_phase = 3;
            end else begin
                m_busy = 1'b0;
                m_last = m_w;
                m_phase = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
